// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned a - b, LSB first, one bit per clock, start/done handshake.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state;
  logic [WIDTH-1:0] a_sh, b_sh, res, res_nxt;
  logic [CW-1:0]    cnt;
  logic             brw, x, y, d, brw_nxt;
  assign x       = a_sh[0];
  assign y       = b_sh[0];
  assign d       = x ^ y ^ brw;
  assign brw_nxt = (~x & y) | (~(x ^ y) & brw);
  // new difference bit enters at the MSB so after WIDTH shifts the result is aligned
  assign res_nxt = (res >> 1) | (WIDTH'(d) << (WIDTH - 1));
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      a_sh       <= '0;
      b_sh       <= '0;
      res        <= '0;
      brw        <= 1'b0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_sh  <= a;
          b_sh  <= b;
          brw   <= 1'b0;
          cnt   <= '0;
          busy  <= 1'b1;
          state <= RUN;
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          brw  <= brw_nxt;
          res  <= res_nxt;
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            diff       <= res_nxt;
            borrow_out <= brw_nxt;
            done       <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: randomized and directed checks of serial_subtractor against an arithmetic model.
module tb_serial_subtractor;
  logic clk = 0, rst = 1;
  logic start8 = 0, busy8, done8, bo8;
  logic [7:0] a8 = 0, b8 = 0, diff8;
  logic start4 = 0, busy4, done4, bo4;
  logic [3:0] a4 = 0, b4 = 0, diff4;
  int tests = 0, fails = 0, cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8));
  serial_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .diff(diff4), .borrow_out(bo4));
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // runs one 8-bit op; lat=-1 on timeout, busy_n counts busy cycles from accept through done
  task automatic do_op(input logic [7:0] ia, input logic [7:0] ib, output int lat, output int busy_n,
                       output logic [7:0] rd, output logic rb, output logic busy_after);
    a8 = ia; b8 = ib; start8 = 1;
    step();
    start8 = 0; a8 = $urandom; b8 = $urandom;
    lat = 0; busy_n = busy8 ? 1 : 0;
    while (!done8 && lat < 40) begin
      step();
      lat++;
      busy_n += busy8 ? 1 : 0;
    end
    if (!done8) lat = -1;
    rd = diff8; rb = bo8;
    step();
    busy_after = busy8;
  endtask
  task automatic test_reset();
    rst = 1; step(); step(); rst = 0;
    tests++;
    if ({busy8, done8, diff8, bo8} !== 11'd0) begin
      fails++; $display("FAIL reset8: got busy=%b done=%b diff=%h bo=%b, want all 0", busy8, done8, diff8, bo8);
    end
    tests++;
    if ({busy4, done4, diff4, bo4} !== 7'd0) begin
      fails++; $display("FAIL reset4: got busy=%b done=%b diff=%h bo=%b, want all 0", busy4, done4, diff4, bo4);
    end
  endtask
  task automatic check_op(input string name, input logic [7:0] ia, input logic [7:0] ib);
    int lat, bn; logic [7:0] rd; logic rb, ba;
    logic [7:0] ed = 8'(int'(ia) - int'(ib));
    logic eb = ia < ib;
    do_op(ia, ib, lat, bn, rd, rb, ba);
    tests++;
    if (lat !== 8) begin fails++; $display("FAIL %s latency: got %0d want 8", name, lat); end
    tests++;
    if (bn !== 9) begin fails++; $display("FAIL %s busy cycles: got %0d want 9", name, bn); end
    tests++;
    if (rd !== ed || rb !== eb) begin
      fails++; $display("FAIL %s result %h-%h: got diff=%h bo=%b want diff=%h bo=%b", name, ia, ib, rd, rb, ed, eb);
    end
    tests++;
    if (ba !== 1'b0 || done8 !== 1'b0) begin
      fails++; $display("FAIL %s after done: got busy=%b done=%b want 0 0", name, ba, done8);
    end
  endtask
  task automatic test_directed();
    check_op("d5a_23", 8'h5A, 8'h23);
    check_op("d10_20", 8'h10, 8'h20);
    check_op("d00_01", 8'h00, 8'h01);
    check_op("da5_a5", 8'hA5, 8'hA5);
    check_op("dff_00", 8'hFF, 8'h00);
  endtask
  task automatic test_random();
    for (int i = 0; i < 20; i++) check_op("rand", 8'($urandom), 8'($urandom));
  endtask
  task automatic test_start_while_busy();
    logic [7:0] prev = diff8;
    int held = 1, extra = 0, lat = 0;
    a8 = 8'h5A; b8 = 8'h23; start8 = 1;
    step();
    start8 = 0;
    for (int i = 0; i < 3; i++) begin step(); if (diff8 !== prev) held = 0; end
    a8 = 8'h01; b8 = 8'h02; start8 = 1;
    step();
    start8 = 0; lat = 4;
    if (diff8 !== prev && !done8) held = 0;
    while (!done8 && lat < 40) begin
      step(); lat++;
      if (!done8 && diff8 !== prev) held = 0;
    end
    tests++;
    if (held !== 1) begin fails++; $display("FAIL hold_diff: diff changed before completion, want %h", prev); end
    tests++;
    if (lat !== 8 || diff8 !== 8'h37 || bo8 !== 1'b0) begin
      fails++; $display("FAIL ignore_start: got lat=%0d diff=%h bo=%b want lat=8 diff=37 bo=0", lat, diff8, bo8);
    end
    for (int i = 0; i < 15; i++) begin step(); if (done8) extra++; end
    tests++;
    if (extra !== 0) begin fails++; $display("FAIL second_done: got %0d extra done pulses want 0", extra); end
  endtask
  task automatic test_reset_mid_run();
    int seen = 0;
    a8 = 8'hC3; b8 = 8'h3C; start8 = 1;
    step();
    start8 = 0;
    for (int i = 0; i < 3; i++) step();
    rst = 1;
    step();
    rst = 0;
    tests++;
    if ({busy8, done8, diff8, bo8} !== 11'd0) begin
      fails++; $display("FAIL mid_reset: got busy=%b done=%b diff=%h bo=%b want all 0", busy8, done8, diff8, bo8);
    end
    for (int i = 0; i < 15; i++) begin step(); if (done8 || busy8) seen++; end
    tests++;
    if (seen !== 0) begin fails++; $display("FAIL mid_reset_quiet: got %0d active cycles want 0", seen); end
    check_op("post_reset", 8'h5A, 8'h23);
  endtask
  task automatic test_back_to_back();
    int i = 0, wait_n, last = -1, bad_res = 0, bad_gap = 0, timeouts = 0;
    logic [3:0] ea, eb;
    ea = 0; eb = 0; a4 = 0; b4 = 0; start4 = 1;
    while (i < 256) begin
      wait_n = 0;
      step();
      while (!done4 && wait_n < 20) begin step(); wait_n++; end
      if (!done4) begin timeouts++; break; end
      if (diff4 !== 4'(int'(ea) - int'(eb)) || bo4 !== (ea < eb)) begin
        bad_res++;
        if (bad_res < 5) $display("FAIL exh4 %h-%h: got diff=%h bo=%b want diff=%h bo=%b",
                                  ea, eb, diff4, bo4, 4'(int'(ea) - int'(eb)), ea < eb);
      end
      if (last >= 0 && cyc - last != 6) bad_gap++;
      last = cyc;
      i++;
      ea = 4'(i >> 4); eb = 4'(i); a4 = ea; b4 = eb;
    end
    start4 = 0;
    tests++;
    if (timeouts !== 0 || i !== 256) begin fails++; $display("FAIL exh4 count: got %0d done pulses want 256", i); end
    tests++;
    if (bad_res !== 0) begin fails++; $display("FAIL exh4 results: got %0d wrong want 0", bad_res); end
    tests++;
    if (bad_gap !== 0) begin fails++; $display("FAIL exh4 spacing: got %0d gaps not 6 want 0", bad_gap); end
  endtask
  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_while_busy();
    test_reset_mid_run();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Multi-cycle, bit-serial unsigned subtractor that computes diff = a - b, LSB first, one bit per clock.
- A single subtractor cell and one borrow flip-flop are reused over WIDTH cycles under FSM control.
- It is the sequential subtract-direction counterpart of the team's combinational half-adder/adder blocks, for area-constrained datapaths.
- Driven by a start/done handshake from a controller or testbench.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 1..32).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on accepted start.
- b  input  WIDTH  subtrahend; captured on accepted start.
- busy  output  1  high while in RUN or DONE.
- done  output  1  one-cycle pulse; result valid.
- diff  output  WIDTH  a - b modulo 2^WIDTH.
- borrow_out  output  1  final borrow; 1 iff a < b (unsigned).

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, busy=0, done=0, diff=0, borrow_out=0. Internal shift registers, borrow FF and counter are cleared.
- rst has priority over every other input. Reset mid-RUN aborts the operation with no done pulse, and outputs return to their reset values.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1 at edge E0:
  - a and b are copied into shift registers, borrow FF=0, bit counter=0.
  - Next state is RUN; busy=1 from the cycle after E0.
- IDLE, start=0: remain in IDLE.
- RUN, each edge:
  - Take LSBs x=a_sh[0], y=b_sh[0], c=borrow FF.
  - d = x^y^c.
  - borrow_next = (~x&y) | (~(x^y)&c).
  - d is shifted into the MSB of the internal result register; a_sh and b_sh shift right by 1; the counter increments.
- RUN, WIDTH-th edge (E0+WIDTH):
  - Internal result complete.
  - diff <= internal result, borrow_out <= borrow_next.
  - Next state is DONE.
- DONE: done=1 for exactly this one cycle (the cycle after E0+WIDTH); busy=1. Next edge goes to IDLE.
- Latency: done is high WIDTH cycles after the start-accept edge (WIDTH+1 cycles from the cycle in which start is presented).
- Throughput: one operation per WIDTH+2 cycles.
- diff and borrow_out update only on the WIDTH-th RUN edge. They hold the previous result throughout a new RUN and until the next completion.
- start while busy (RUN or DONE) is ignored. a and b may change freely after the accept edge without affecting the operation.
- start held continuously: a new operation is accepted in the first IDLE cycle after DONE.
- Arithmetic: result equals (a - b) mod 2^WIDTH; borrow_out = (a < b).
- WIDTH=1 degenerates to a registered full subtractor with borrow-in 0: 1 RUN cycle.
- Counter width is $clog2(WIDTH+1). No counter overflow is possible for WIDTH<=32.

Test Plan:
- WIDTH=8, a=8'h5A, b=8'h23, pulse start -> done pulses exactly 8 cycles after the accept edge; diff=8'h37, borrow_out=0; busy high for 9 cycles.
- a=8'h10, b=8'h20 -> diff=8'hF0, borrow_out=1. Then a=8'h00, b=8'h01 -> diff=8'hFF, borrow_out=1 (full borrow ripple).
- a=b=8'hA5 -> diff=8'h00, borrow_out=0. Then a=8'hFF, b=8'h00 -> diff=8'hFF, borrow_out=0.
- Start op (8'h5A-8'h23); pulse start with a=8'h01, b=8'h02 during RUN -> ignored; result 8'h37, no second done. diff keeps the old value until completion.
- Assert rst for 1 cycle at RUN cycle 4 -> next cycle busy=0, done=0, diff=0, borrow_out=0, no done pulse. A new start afterward yields a correct result.
- Exhaustive check with WIDTH=4, all 256 (a,b) pairs back-to-back with start held high -> every done matches the reference model (a-b)&4'hF and a<b; spacing is 6 cycles.
